// File: rtl/mux_gate_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_gate_scheduler_if : request/response bundle of the scheduler |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mux_gate_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*3-1:0]     req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_gate_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_gate_scheduler : round-robin shared bit-serial 2x1-mux cell   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mux_gate_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input wire                  clk,
  input wire                  rst_n,
  mux_gate_scheduler_if.slave bus
);
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             rsp_valid_q;
  logic             busy_q;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [NUM_REQ-1:0] w_grant;
  logic [2:0]         w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_d0;
  logic               w_d1;
  logic               w_bit;
  int                 w_dist;
  int                 w_best;

  // Winner is the valid requester with the smallest rotated distance past rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_dist  = 0;
    w_best  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(rr_ptr_q)) % NUM_REQ;
      if (bus.req_valid[i] && (!w_found || (w_dist < w_best))) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_win   = IDW'(i);
      end
    end
  end

  always_comb begin
    w_op    = '0;
    w_a     = '0;
    w_b     = '0;
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_op = bus.req_op[3*i +: 3];
        w_a  = bus.req_a[WIDTH*i +: WIDTH];
        w_b  = bus.req_b[WIDTH*i +: WIDTH];
        w_grant[i] = rst_n && (state_q == S_IDLE) && w_found;
      end
    end
  end

  // Operands are shifted right each bit, so bit k of the request is always at [0].
  always_comb begin
    w_d1 = 1'b0;
    w_d0 = 1'b0;
    case (op_q)
      3'd0: begin w_d1 = b_q[0];  w_d0 = 1'b0;   end
      3'd1: begin w_d1 = 1'b1;    w_d0 = b_q[0]; end
      3'd2: begin w_d1 = 1'b0;    w_d0 = 1'b1;   end
      3'd3: begin w_d1 = ~b_q[0]; w_d0 = 1'b1;   end
      3'd4: begin w_d1 = 1'b0;    w_d0 = ~b_q[0]; end
      3'd5: begin w_d1 = ~b_q[0]; w_d0 = b_q[0]; end
      3'd6: begin w_d1 = b_q[0];  w_d0 = ~b_q[0]; end
      3'd7: begin w_d1 = 1'b1;    w_d0 = 1'b0;   end
    endcase
    w_bit  = a_q[0] ? w_d1 : w_d0;
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CW'(i)) data_d[i] = w_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            state_q  <= S_BUSY;
            busy_q   <= 1'b1;
            rr_ptr_q <= w_win;
            id_q     <= w_win;
            op_q     <= w_op;
            a_q      <= w_a;
            b_q      <= w_b;
            cnt_q    <= '0;
            data_q   <= '0;
          end
        end
        S_BUSY: begin
          data_q <= data_d;
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_gate_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_gate_scheduler : directed bench for mux_gate_scheduler     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mux_gate_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mux_gate_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  mux_gate_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[i]             = v;
    bus.req_op[3*i +: 3]         = op;
    bus.req_a[WIDTH*i +: WIDTH]  = a;
    bus.req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic wait_grant(input logic [3:0] exp_ready, input string nm);
    int t = 0;
    while (bus.req_ready == 4'b0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check(nm, 32'(bus.req_ready), 32'(exp_ready));
  endtask

  // Entered at the negedge right after the accept edge.
  task automatic count_latency(input string nm);
    check({nm, "_lat0"}, 32'(bus.rsp_valid), 0);
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      check($sformatf("%s_lat%0d", nm, k), 32'(bus.rsp_valid), 32'(k == WIDTH));
    end
  endtask

  task automatic finish_rsp(input logic [1:0] id, input logic [7:0] data,
                            input int stall, input string nm);
    int t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_valid"}, 32'(bus.rsp_valid), 1);
    check({nm, "_id"},    32'(bus.rsp_id), 32'(id));
    check({nm, "_data"},  32'(bus.rsp_data), 32'(data));
    check({nm, "_busy"},  32'(bus.busy), 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(bus.rsp_valid), 1);
      check({nm, "_hold_data"},  32'(bus.rsp_data), 32'(data));
      check({nm, "_hold_ready"}, 32'(bus.req_ready), 0);
      check({nm, "_hold_busy"},  32'(bus.busy), 1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check({nm, "_done_noacc"}, 32'(bus.req_ready), 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({nm, "_post_valid"}, 32'(bus.rsp_valid), 0);
    check({nm, "_post_busy"},  32'(bus.busy), 0);
    check({nm, "_post_data"},  32'(bus.rsp_data), 32'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[12];
    logic [7:0]    rr_exp[4];

    vecs[0]  = '{3'd5, 8'hA5, 8'h0F, 8'hAA};
    vecs[1]  = '{3'd0, 8'hCC, 8'hAA, 8'h88};
    vecs[2]  = '{3'd1, 8'hCC, 8'hAA, 8'hEE};
    vecs[3]  = '{3'd2, 8'hCC, 8'hAA, 8'h33};
    vecs[4]  = '{3'd3, 8'hCC, 8'hAA, 8'h77};
    vecs[5]  = '{3'd4, 8'hCC, 8'hAA, 8'h11};
    vecs[6]  = '{3'd5, 8'hCC, 8'hAA, 8'h66};
    vecs[7]  = '{3'd6, 8'hCC, 8'hAA, 8'h99};
    vecs[8]  = '{3'd7, 8'hCC, 8'hAA, 8'hCC};
    vecs[9]  = '{3'd1, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{3'd3, 8'hFF, 8'hFF, 8'h00};
    vecs[11] = '{3'd2, 8'h00, 8'h5A, 8'hFF};
    rr_exp[0] = 8'h88;
    rr_exp[1] = 8'hEE;
    rr_exp[2] = 8'h33;
    rr_exp[3] = 8'h77;

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset with a 4-way tie pending; requester i uses opcode i.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'(i), 8'hCC, 8'hAA);
    #3;
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_id",    32'(bus.rsp_id), 0);
    check("rst_data",  32'(bus.rsp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("tie_first", 32'(bus.req_ready), 32'h1);

    // Round-robin with all requesters held valid; second response is back-pressured.
    for (int g = 0; g < 5; g++) begin
      wait_grant(4'(1 << (g % 4)), $sformatf("rr%0d_grant", g));
      @(negedge clk);
      count_latency($sformatf("rr%0d", g));
      finish_rsp(2'(g % 4), rr_exp[g % 4], (g == 1) ? 5 : 0, $sformatf("rr%0d", g));
    end
    bus.req_valid = '0;

    // Single-requester vectors; operands are scrambled right after the accept.
    for (int v = 0; v < 12; v++) begin
      set_req(0, 1'b1, vecs[v].op, vecs[v].a, vecs[v].b);
      #1;
      wait_grant(4'h1, $sformatf("vec%0d_grant", v));
      @(negedge clk);
      check($sformatf("vec%0d_busy", v), 32'(bus.busy), 1);
      set_req(0, 1'b0, ~vecs[v].op, ~vecs[v].a, ~vecs[v].b);
      count_latency($sformatf("vec%0d", v));
      finish_rsp(2'd0, vecs[v].exp, 0, $sformatf("vec%0d", v));
    end

    // Reset while req2 is at bit 3, then req2 must win again over req3.
    set_req(2, 1'b1, 3'd5, 8'hA5, 8'h0F);
    #1;
    wait_grant(4'h4, "mid_grant");
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("mid_partial", 32'(bus.rsp_data), 32'h02);
    check("mid_busy",    32'(bus.busy), 1);
    set_req(3, 1'b1, 3'd0, 8'hFF, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_data",  32'(bus.rsp_data), 0);
    check("mid_rst_id",    32'(bus.rsp_id), 0);
    check("mid_rst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("mid_rst_hold_valid", 32'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    #1;
    check("mid_rr_reset", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    count_latency("mid_again");
    finish_rsp(2'd2, 8'hAA, 0, "mid_again");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
